// File: rtl/led_pattern_pkg.sv
// Shared encodings and default step dividers for the LED pattern engine.
// The optional pause input is enabled with the LED_PATTERN_PAUSE_EN macro.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_CHASE2 = 2'd0,
    MODE_FILL   = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  localparam int DIV_FAST_DEF = 50_000_000;
  localparam int DIV_SLOW_DEF = 100_000_000;

endpackage

// File: rtl/led_tick_gen.sv
// Step prescaler: counts 0..DIV-1 and emits a one-cycle tick on the last count.
// Clear restarts the count; hold freezes it without producing ticks.
module led_tick_gen #(
  parameter int DIV_FAST = 2,
  parameter int DIV_SLOW = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_fast,
  input  logic i_clr,
  input  logic i_hold,
  output logic o_tick
);

  localparam int DMAX = (DIV_FAST > DIV_SLOW) ? DIV_FAST : DIV_SLOW;
  localparam int CW   = $clog2(DMAX);
  localparam logic [CW-1:0] C_ONE = 1;

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_last;
  logic          w_at_last;

  assign w_last    = i_fast ? CW'(DIV_FAST - 1) : CW'(DIV_SLOW - 1);
  assign w_at_last = (r_cnt == w_last);
  // A clear wins over a coincident tick so the dropped step is never counted.
  assign o_tick    = w_at_last && !i_clr && !i_hold;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr)
      r_cnt <= '0;
    else if (!i_hold)
      r_cnt <= w_at_last ? '0 : r_cnt + C_ONE;
  end

endmodule

// File: rtl/led_pattern_engine.sv
// LED pattern generator: chase, fill/empty, bounce and blink driven by a step tick.
// Define LED_PATTERN_PAUSE_EN to add a pause input that freezes stepping and the LEDs.
module led_pattern_engine
  import led_pattern_pkg::*;
#(
  parameter int N_LED    = 8,
  parameter int DIV_FAST = DIV_FAST_DEF,
  parameter int DIV_SLOW = DIV_SLOW_DEF
) (
  input  logic             clki,
  input  logic             rs,
  input  logic [1:0]       mode,
  input  logic             speed,
`ifdef LED_PATTERN_PAUSE_EN
  input  logic             pause,
`endif
  output logic [N_LED-1:0] led
);

  localparam int SW = $clog2(2 * N_LED);
  localparam logic [N_LED-1:0] L_ONE  = 1;
  localparam logic [N_LED-1:0] L_PAIR = 3;
  localparam logic [SW-1:0]    S_ONE  = 1;

  mode_e             r_mode;
  logic              r_speed;
  logic [SW-1:0]     r_s;
  logic [N_LED-1:0]  r_led;
  logic [SW-1:0]     w_last;
  logic [SW-1:0]     w_pos;
  logic [N_LED-1:0]  w_led;
  logic              w_pause, w_mode_chg, w_spd_chg, w_clr, w_tick;

`ifdef LED_PATTERN_PAUSE_EN
  assign w_pause = pause;
`else
  assign w_pause = 1'b0;
`endif

  // While paused the registered mode/speed freeze too, so a change made
  // during the pause is still seen as a change once stepping resumes.
  assign w_mode_chg = (mode_e'(mode) != r_mode);
  assign w_spd_chg  = (speed != r_speed);
  assign w_clr      = !w_pause && (w_mode_chg || w_spd_chg);

  led_tick_gen #(
    .DIV_FAST(DIV_FAST),
    .DIV_SLOW(DIV_SLOW)
  ) u_tick (
    .i_clk (clki),
    .i_rst (rs),
    .i_fast(speed),
    .i_clr (w_clr),
    .i_hold(w_pause),
    .o_tick(w_tick)
  );

  always_comb begin
    case (r_mode)
      MODE_CHASE2: w_last = SW'(N_LED - 2);
      MODE_FILL:   w_last = SW'(2 * N_LED - 1);
      MODE_BOUNCE: w_last = SW'(2 * N_LED - 3);
      default:     w_last = S_ONE;
    endcase
  end

  // Fill uses (1<<k)-1 in N_LED bits; k = N_LED shifts to zero and wraps to all-ones.
  always_comb begin
    w_pos = '0;
    w_led = '0;
    case (r_mode)
      MODE_CHASE2: w_led = L_PAIR << r_s;
      MODE_FILL: begin
        w_pos = (r_s <= SW'(N_LED)) ? r_s : SW'(2 * N_LED - int'(r_s));
        w_led = (L_ONE << w_pos) - L_ONE;
      end
      MODE_BOUNCE: begin
        w_pos = (r_s < SW'(N_LED)) ? r_s : SW'(2 * N_LED - 2 - int'(r_s));
        w_led = L_ONE << w_pos;
      end
      default: w_led = {N_LED{r_s[0]}};
    endcase
  end

  always_ff @(posedge clki) begin
    if (rs) begin
      r_mode  <= mode_e'(mode);
      r_speed <= speed;
      r_s     <= '0;
      r_led   <= '0;
    end else if (!w_pause) begin
      r_mode  <= mode_e'(mode);
      r_speed <= speed;
      r_led   <= w_led;
      if (w_mode_chg)
        r_s <= '0;
      else if (w_tick)
        r_s <= (r_s == w_last) ? '0 : r_s + S_ONE;
    end
  end

  assign led = r_led;

endmodule
